// File: rtl/protocol_receiver.sv
// protocol_receiver
//   Receive stage for the 32-bit link word stream. Hunts for frame headers
//   (sync byte in [31:24], payload length in [15:0]), writes payload into a
//   circular FIFO at a speculative write pointer and commits the frame only
//   when it completes cleanly. The CPU drains committed words and reads
//   status through an Avalon-MM slave with one-cycle read latency.
//
//   Build option: define PROTOCOL_RX_CHECKSUM_EN to expect a trailing
//   checksum word (sum of payload mod 2^32) per frame. Without it a frame
//   commits on its last payload word and csum_err reads 0.
//
// Ports
//   clock, reset     system clock, synchronous active-high reset
//   link_valid       link_data carries a word this cycle
//   link_data[31:0]  header / payload / checksum word
//   link_ready       word accepted this cycle (transfer = valid & ready)
//   address[1:0]     register select: 0 pop data, 1 status, 2 control, 3 FSM
//   read, readdata   read strobe; readdata registered, valid next cycle
//   write, writedata control write (addr 2: bit0 clr errors, bit1 flush,
//                    bit2 irq_en)
//   irq              high while committed level != 0 and irq_en set
module protocol_receiver #(
  parameter int unsigned DEPTH = 16,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        link_valid,
  input  logic [31:0] link_data,
  output logic        link_ready,
  input  logic [1:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        irq
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam logic [AW:0] DEPTH_W = PW'(DEPTH);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] rd_ptr, wr_commit, wr_spec, wr_spec_nxt;
  logic [AW:0] level, stored;
  logic [16:0] free;
  logic        full;
  logic [15:0] remain;
  logic [15:0] hdr_len;
  logic        too_long;
  logic [31:0] mem [DEPTH];

  logic [7:0]  frame_count;
  logic        sync_err, len_err, csum_err, underflow, irq_en;

  logic        xfer, flush, clr_err, cfg_wr;
  logic        pop_req, pop;
  logic        wr_en, hdr_ok, hdr_valid, set_sync, set_len, set_csum;
  logic        commit, discard, count_frame;

  logic        unused;
  assign unused = ^{link_data[23:16], writedata[31:3]};

  assign level    = wr_commit - rd_ptr;
  assign stored   = wr_spec - rd_ptr;
  assign full     = (stored == DEPTH_W);
  assign free     = 17'(DEPTH) - 17'(stored);
  assign hdr_len  = link_data[15:0];
  assign too_long = ({1'b0, hdr_len} > free);

  assign link_ready = !((state == PAYLOAD) && full);
  assign irq        = irq_en && (level != '0);

  assign cfg_wr  = write && (address == 2'd2);
  assign flush   = cfg_wr && writedata[1];
  assign clr_err = cfg_wr && writedata[0];
  // A word arriving in the same cycle as a flush is dropped.
  assign xfer    = link_valid && link_ready && !flush;

  assign pop_req = read && (address == 2'd0);
  assign pop     = pop_req && (level != '0);

  assign wr_spec_nxt = wr_spec + PW'(wr_en);

  always_ff @(posedge clock) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

`ifdef PROTOCOL_RX_CHECKSUM_EN
  logic [31:0] sum;
  always_ff @(posedge clock) begin
    if (hdr_valid)  sum <= 32'd0;
    else if (wr_en) sum <= sum + link_data;
  end
`endif

  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    hdr_ok      = 1'b0;
    hdr_valid   = 1'b0;
    set_sync    = 1'b0;
    set_len     = 1'b0;
    set_csum    = 1'b0;
    commit      = 1'b0;
    discard     = 1'b0;
    count_frame = 1'b0;
    if (flush) begin
      state_nxt = HUNT;
    end else if (xfer) begin
      unique case (state)
        HUNT: begin
          if (link_data[31:24] != SYNC) begin
            set_sync = 1'b1;
          end else if (hdr_len == 16'd0) begin
            hdr_valid = 1'b1;
`ifdef PROTOCOL_RX_CHECKSUM_EN
            state_nxt = CHECK;
`else
            count_frame = 1'b1;
`endif
          end else if (too_long) begin
            set_len = 1'b1;
          end else begin
            hdr_valid = 1'b1;
            hdr_ok    = 1'b1;
            state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          wr_en = 1'b1;
          if (remain == 16'd1) begin
`ifdef PROTOCOL_RX_CHECKSUM_EN
            state_nxt = CHECK;
`else
            commit      = 1'b1;
            count_frame = 1'b1;
            state_nxt   = HUNT;
`endif
          end
        end
`ifdef PROTOCOL_RX_CHECKSUM_EN
        CHECK: begin
          state_nxt = HUNT;
          if (link_data == sum) begin
            commit      = 1'b1;
            count_frame = 1'b1;
          end else begin
            discard  = 1'b1;
            set_csum = 1'b1;
          end
        end
`endif
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_spec[AW-1:0]] <= link_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_commit   <= '0;
      wr_spec     <= '0;
      remain      <= 16'd0;
      frame_count <= 8'd0;
      sync_err    <= 1'b0;
      len_err     <= 1'b0;
      underflow   <= 1'b0;
      irq_en      <= 1'b0;
      readdata    <= 32'd0;
    end else begin
      if (flush) begin
        rd_ptr    <= '0;
        wr_commit <= '0;
        wr_spec   <= '0;
      end else begin
        if (pop)     rd_ptr    <= rd_ptr + 1'b1;
        if (commit)  wr_commit <= wr_spec_nxt;
        if (discard) wr_spec   <= wr_commit;
        else         wr_spec   <= wr_spec_nxt;
      end

      if (hdr_ok)     remain <= hdr_len;
      else if (wr_en) remain <= remain - 16'd1;

      if (count_frame) frame_count <= frame_count + 8'd1;

      // Setting an error bit takes priority over a clear in the same cycle.
      sync_err  <= set_sync | (sync_err & ~clr_err);
      len_err   <= set_len | (len_err & ~clr_err);
      underflow <= (pop_req && (level == '0)) | (underflow & ~clr_err);

      if (cfg_wr) irq_en <= writedata[2];

      if (read) begin
        unique case (address)
          2'd0:    readdata <= pop ? mem[rd_ptr[AW-1:0]] : 32'd0;
          2'd1:    readdata <= {frame_count, 7'd0, 9'(level), 3'd0,
                                irq_en, underflow, len_err, csum_err, sync_err};
          2'd3:    readdata <= {30'd0, state};
          default: readdata <= 32'd0;
        endcase
      end
    end
  end

`ifdef PROTOCOL_RX_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) csum_err <= 1'b0;
    else       csum_err <= set_csum | (csum_err & ~clr_err);
  end
`else
  logic unused_csum;
  assign unused_csum = set_csum ^ discard;
  assign csum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_protocol_receiver.sv
module tb_protocol_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        link_valid;
  logic [31:0] link_data;
  logic        link_ready;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic        irq;

  protocol_receiver #(.DEPTH(16), .SYNC(8'hA5)) dut (
    .clock      (clock),
    .reset      (reset),
    .link_valid (link_valid),
    .link_data  (link_data),
    .link_ready (link_ready),
    .address    (address),
    .read       (read),
    .readdata   (readdata),
    .write      (write),
    .writedata  (writedata),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  localparam int OP_LINK = 0;
  localparam int OP_RD0  = 1;
  localparam int OP_RD1  = 2;
  localparam int OP_RD3  = 3;
  localparam int OP_WR2  = 4;

  typedef struct {
    int          op;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input int op, input logic [31:0] data, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.data = data; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input logic lv, input logic [31:0] ld, input logic rd,
                      input logic wr, input logic [1:0] a, input logic [31:0] wd);
    link_valid = lv; link_data = ld; read = rd; write = wr;
    address = a; writedata = wd;
    @(posedge clock); #1;
    link_valid = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    chk("link_ready", {31'd0, link_ready}, 32'd1);
    step(1'b1, w, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    step(1'b0, 32'd0, 1'b1, 1'b0, a, 32'd0);
    d = readdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    reset = 1'b1; link_valid = 1'b0; link_data = 32'd0; address = 2'd0;
    read = 1'b0; write = 1'b0; writedata = 32'd0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    chk("rst_link_ready", {31'd0, link_ready}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);

    add(OP_RD1, 0, 32'h0000_0000);
    add(OP_RD3, 0, 32'd0);
`ifdef PROTOCOL_RX_CHECKSUM_EN
    add(OP_LINK, 32'hA500_0003, 0); add(OP_LINK, 1, 0); add(OP_LINK, 2, 0);
    add(OP_RD3, 0, 32'd1);
    add(OP_LINK, 3, 0);
    add(OP_RD3, 0, 32'd2);
    add(OP_LINK, 6, 0);
    add(OP_RD3, 0, 32'd0);
    add(OP_RD1, 0, 32'h0100_0300);
    add(OP_RD0, 0, 1); add(OP_RD0, 0, 2); add(OP_RD0, 0, 3); add(OP_RD0, 0, 0);
    add(OP_RD1, 0, 32'h0100_0008);
    add(OP_WR2, 1, 0);
    add(OP_RD1, 0, 32'h0100_0000);
    add(OP_LINK, 32'hA500_0003, 0); add(OP_LINK, 1, 0); add(OP_LINK, 2, 0);
    add(OP_LINK, 3, 0); add(OP_LINK, 7, 0);
    add(OP_RD1, 0, 32'h0100_0002);
    add(OP_LINK, 32'hA500_0002, 0); add(OP_LINK, 32'h10, 0); add(OP_LINK, 32'h20, 0);
    add(OP_LINK, 32'h30, 0);
    add(OP_RD1, 0, 32'h0200_0202);
    add(OP_RD0, 0, 32'h10); add(OP_RD0, 0, 32'h20);
    add(OP_WR2, 1, 0);
    add(OP_LINK, 32'hA500_0011, 0);
    add(OP_RD3, 0, 32'd0);
    add(OP_RD1, 0, 32'h0200_0004);
    add(OP_LINK, 5, 0);
    add(OP_RD1, 0, 32'h0200_0005);
    add(OP_WR2, 1, 0);
    add(OP_LINK, 32'hA500_0000, 0);
    add(OP_RD3, 0, 32'd2);
    add(OP_LINK, 0, 0);
    add(OP_RD1, 0, 32'h0300_0000);
`else
    add(OP_LINK, 32'hA500_0003, 0); add(OP_LINK, 1, 0); add(OP_LINK, 2, 0);
    add(OP_RD3, 0, 32'd1);
    add(OP_LINK, 3, 0);
    add(OP_RD3, 0, 32'd0);
    add(OP_RD1, 0, 32'h0100_0300);
    add(OP_RD0, 0, 1); add(OP_RD0, 0, 2); add(OP_RD0, 0, 3); add(OP_RD0, 0, 0);
    add(OP_RD1, 0, 32'h0100_0008);
    add(OP_WR2, 1, 0);
    add(OP_RD1, 0, 32'h0100_0000);
    add(OP_LINK, 32'hA500_0011, 0);
    add(OP_RD3, 0, 32'd0);
    add(OP_RD1, 0, 32'h0100_0004);
    add(OP_LINK, 5, 0);
    add(OP_RD1, 0, 32'h0100_0005);
    add(OP_WR2, 1, 0);
    add(OP_LINK, 32'hA500_0002, 0);
    add(OP_RD3, 0, 32'd1);
    add(OP_LINK, 9, 0); add(OP_LINK, 10, 0);
    add(OP_RD3, 0, 32'd0);
    add(OP_RD1, 0, 32'h0200_0200);
    add(OP_LINK, 32'hA500_0000, 0);
    add(OP_RD1, 0, 32'h0300_0200);
    add(OP_RD0, 0, 9); add(OP_RD0, 0, 10);
`endif
    add(OP_LINK, 32'hA500_0010, 0);
    add(OP_RD3, 0, 32'd1);
    add(OP_WR2, 2, 0);
    add(OP_RD3, 0, 32'd0);
    add(OP_WR2, 4, 0);
    add(OP_RD1, 0, 32'h0300_0010);

    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      case (tbl[i].op)
        OP_LINK: send(tbl[i].data);
        OP_RD0:  begin rd(2'd0, d); chk({nm, "_rd0"}, d, tbl[i].exp); end
        OP_RD1:  begin rd(2'd1, d); chk({nm, "_status"}, d, tbl[i].exp); end
        OP_RD3:  begin rd(2'd3, d); chk({nm, "_state"}, d, tbl[i].exp); end
        default: step(1'b0, 32'd0, 1'b0, 1'b1, 2'd2, tbl[i].data);
      endcase
    end

    // Fill to 14, then a length-2 frame whose final transfer coincides with a pop.
    do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b1, 2'd2, 32'd4);
    send(32'hA500_000E);
    for (int k = 1; k <= 14; k++) send(k);
`ifdef PROTOCOL_RX_CHECKSUM_EN
    send(32'd105);
`endif
    chk("fill_irq", {31'd0, irq}, 32'd1);
    send(32'hA500_0002);
    send(32'd100);
`ifdef PROTOCOL_RX_CHECKSUM_EN
    send(32'd101);
    chk("commit_pop_ready", {31'd0, link_ready}, 32'd1);
    step(1'b1, 32'd201, 1'b1, 1'b0, 2'd0, 32'd0);
`else
    chk("commit_pop_ready", {31'd0, link_ready}, 32'd1);
    step(1'b1, 32'd101, 1'b1, 1'b0, 2'd0, 32'd0);
`endif
    chk("commit_pop_data", readdata, 32'd1);
    rd(2'd1, d);
    chk("commit_pop_status", d, 32'h0200_0F10);

    // Reset in the middle of a 4-word frame.
    rd(2'd0, d); chk("drain2", d, 32'd2);
    rd(2'd0, d); chk("drain3", d, 32'd3);
    rd(2'd0, d); chk("drain4", d, 32'd4);
    send(32'hA500_0004);
    send(32'd1);
    send(32'd2);
    rd(2'd3, d); chk("mid_state", d, 32'd1);
    chk("mid_irq", {31'd0, irq}, 32'd1);
    do_reset();
    chk("mr_link_ready", {31'd0, link_ready}, 32'd1);
    chk("mr_readdata", readdata, 32'd0);
    chk("mr_irq", {31'd0, irq}, 32'd0);
    rd(2'd1, d); chk("mr_status", d, 32'd0);
    rd(2'd3, d); chk("mr_state", d, 32'd0);

    // Flush drops a same-cycle header; then set beats clear.
    send(32'hA500_0001);
    send(32'h77);
`ifdef PROTOCOL_RX_CHECKSUM_EN
    send(32'h77);
`endif
    step(1'b1, 32'hA500_0001, 1'b0, 1'b1, 2'd2, 32'd2);
    send(32'h33);
    rd(2'd1, d); chk("flush_status", d, 32'h0100_0001);
    rd(2'd3, d); chk("flush_state", d, 32'd0);
    rd(2'd0, d); chk("flush_rd0", d, 32'd0);
    step(1'b1, 32'h44, 1'b0, 1'b1, 2'd2, 32'd1);
    rd(2'd1, d); chk("set_wins", d, 32'h0100_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/protocol_receiver.md
# protocol_receiver

Link-side receive stage that consumes the 32-bit word stream produced by the protocol sender interface, hunts for frame headers, buffers payload in an internal FIFO, verifies a per-frame checksum and commits only good frames. The CPU drains committed payload and reads status through an Avalon-MM slave port with one-cycle read latency. Sits directly downstream of the sender's `data_export` bus on the same clock domain.

## Interface
- `DEPTH`, 16: payload FIFO depth in words; power of two, 4–256.
- `SYNC`, 8'hA5: header sync byte expected in bits [31:24].
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `link_valid`  in  1  `link_data` carries a word this cycle.
- `link_data`  in  32  incoming word (header, payload or checksum).
- `link_ready`  out  1  block accepts a word this cycle; transfer = `link_valid & link_ready`.
- `address`  in  2  Avalon register select.
- `read`  in  1  Avalon read strobe.
- `readdata`  out  32  read data, valid the cycle after `read`.
- `write`  in  1  Avalon write strobe.
- `writedata`  in  32  Avalon write data.
- `irq`  out  1  high while committed words ≥1 and IRQ enabled.

## Operation
- Header: [31:24]=`SYNC`, [23:16] ignored, [15:0]=length N (payload words).
- FSM `HUNT` → `PAYLOAD` → `CHECK` → `HUNT`.
  - `HUNT`: words with wrong sync byte dropped, `sync_err` set. Valid header: N=0 → `CHECK`; N > free space (DEPTH − total stored incl. uncommitted) → drop frame: `len_err` set, stay `HUNT` (payload then discarded as non-sync words); else latch N, clear sum, → `PAYLOAD`.
  - `PAYLOAD`: each transfer written at speculative pointer `wr_spec`, sum += word (mod 2^32), count down; after Nth word → `CHECK`.
  - `CHECK`: next transfer compared to sum. Match: `wr_commit ← wr_spec`, `frame_count` +1 (8-bit, wraps 255→0). Mismatch: `wr_spec ← wr_commit` (frame discarded), `csum_err` set. → `HUNT`.
- `link_ready` = 1 except in `PAYLOAD` when FIFO full; never deasserted in `HUNT`/`CHECK`.
- Registers:
  - addr 0 read: head word of committed data, pop. Empty → returns 0, no pop, `underflow` set.
  - addr 1 read: {`frame_count`[31:24], 7'b0, `level`[16:8] (committed words), 3'b0, `irq_en`[4], `underflow`[3], `len_err`[2], `csum_err`[1], `sync_err`[0]}.
  - addr 2 write: bit0 clears all error bits; bit1 flush: all pointers reset, FSM → `HUNT`; bit2 → `irq_en`.
  - addr 3 read: current FSM state (0/1/2) in [1:0]. Writes to 0/1/3 ignored.
- Simultaneous pop and commit: both take effect; level = old + committed − 1.
- Error-set and clear same cycle: set wins.

## Timing
- Reset: `link_ready`=1, `readdata`=0, `irq`=0, all pointers/counters/flags 0, `irq_en`=0, FSM `HUNT`.
- Reset mid-frame: uncommitted and committed data lost; no frame counted.
- Link word accepted → stored same edge; committed data visible to addr 0 read issued the cycle after the checksum transfer.
- `readdata` registered: `read` at cycle t → data at t+1; holds until next read.
- Flush takes effect on the write edge; a link word transferring the same cycle is dropped.
- Back-to-back frames: header may arrive the cycle after checksum, zero bubble.

## Configuration
- `PROTOCOL_RX_CHECKSUM_EN` defined: `CHECK` state present as above.
- Undefined: no checksum word on the link; frame commits on the Nth payload transfer (N=0 frames count immediately in `HUNT`), `csum_err` reads 0, sum logic removed.

## Test plan
- Header 0xA5000003, payload 1,2,3, checksum 6 → `frame_count`=1, level=3, three addr-0 reads return 1,2,3, then 0 with `underflow`=1.
- Same frame with checksum 7 → `csum_err`=1, level=0, following good frame commits normally.
- DEPTH=16, header length 17 → `len_err`=1, FSM stays `HUNT`, `sync_err` set by discarded payload.
- Fill 14 committed words, send length-2 frame while holding reads, then pop 1 word during payload → `link_ready` never drops; commit + pop same cycle gives level 15.
- Assert `reset` in `PAYLOAD` after 2 of 4 words → all outputs at reset values next cycle, level=0.
- Build without `PROTOCOL_RX_CHECKSUM_EN`: header length 2, words 9,10 → commit on second word, next word 0xA5000000 counts a frame, `frame_count`=2.
